// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes and the sequencer state type.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring divide).
// Ports: clk, reset (sync, active-high), start, funct3, a, b -> busy, done, result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_if(input logic s, input logic [XLEN-1:0] x);
        return s ? neg(x) : x;
    endfunction

    md_state_e         state;
    logic [2:0]        op;
    logic              sa, sb;
    logic [XLEN-1:0]   ma, mb;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;

    // Operand decode at launch
    logic            a_sgn, b_sgn, sa_in, sb_in;
    logic [XLEN-1:0] ma_in, mb_in;
    logic            div_zero, ovf, fast;
    logic [XLEN-1:0] fast_res;

    assign a_sgn = (funct3 == F3_MULH) | (funct3 == F3_MULHSU)
                 | (funct3 == F3_DIV)  | (funct3 == F3_REM);
    assign b_sgn = (funct3 == F3_MULH) | (funct3 == F3_DIV)
                 | (funct3 == F3_REM);
    assign sa_in = a_sgn & a[XLEN-1];
    assign sb_in = b_sgn & b[XLEN-1];
    assign ma_in = abs_if(sa_in, a);
    assign mb_in = abs_if(sb_in, b);

    assign div_zero = funct3[2] && (b == '0);
    assign ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                   && (a == MIN) && (b == '1);
    assign fast     = div_zero || ovf;
    // funct3[1] separates REM* from DIV* among divide ops
    assign fast_res = div_zero ? (funct3[1] ? a : '1)
                               : (funct3[1] ? '0 : a);

    // One multiply step: conditional add into the high half, then shift right
    logic [XLEN:0]     add_hi;
    logic [2*XLEN-1:0] mul_next;

    assign add_hi   = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, ma} : '0);
    assign mul_next = {add_hi, acc[XLEN-1:1]};

    // One restoring divide step; quotient shifts through acc low half
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] rem_next, quo_next;

    assign shifted  = {rem, acc[XLEN-1]};
    assign trial    = shifted - {1'b0, mb};
    assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next = {acc[XLEN-2:0], ~trial[XLEN]};

    // Sign correction and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign prod  = (sa ^ sb) ? (~acc + (2*XLEN)'(1)) : acc;
    assign quo_s = abs_if(sa ^ sb, acc[XLEN-1:0]);
    assign rem_s = abs_if(sa, rem);
    assign fix_res = op[2] ? (op[1] ? rem_s : quo_s)
                           : ((op == F3_MUL) ? prod[XLEN-1:0]
                                             : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op     <= F3_MUL;
            sa     <= 1'b0;
            sb     <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op  <= funct3;
                        sa  <= sa_in;
                        sb  <= sb_in;
                        ma  <= ma_in;
                        mb  <= mb_in;
                        cnt <= '0;
                        rem <= '0;
                        acc <= funct3[2] ? {XLEN'(0), ma_in}
                                         : {XLEN'(0), mb_in};
                        if (fast) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (op[2]) begin
                        acc <= {acc[2*XLEN-1:XLEN], quo_next};
                        rem <= rem_next;
                    end else begin
                        acc <= mul_next;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed ISA cases, handshake,
// reset abort, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int total  = 0;
    int passed = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_md(input logic [2:0] f,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0] xe, ye, p;
        logic        ovf;
        xe  = (f == 3'd1 || f == 3'd2) ? {{32{x[31]}}, x} : {32'b0, x};
        ye  = (f == 3'd1) ? {{32{y[31]}}, y} : {32'b0, y};
        p   = xe * ye;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] f,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
        bit sdiv;
        sdiv = (f == 3'd4) || (f == 3'd6);
        return f[2] && ((y == 0)
            || (sdiv && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Raise start with an op; returns positioned in cycle 1.
    task automatic launch(input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe from cycle 'first' until done; returns in the done cycle.
    task automatic wait_done(input int first, input bit fast,
                             output int cyc, output int bad);
        cyc = -1;
        bad = 0;
        for (int n = first; n <= 60; n++) begin
            if (done) begin
                if (busy !== 1'b0) bad++;
                cyc = n;
                break;
            end
            if (busy !== !fast) bad++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input bit fast);
        int cyc, bad;
        launch(f, x, y);
        wait_done(1, fast, cyc, bad);
        chk({tag, "_cycle"}, cyc, fast ? 1 : 34);
        chk({tag, "_busy"}, bad, 0);
        chk({tag, "_res"}, result, exp);
    endtask

    logic [2:0]  t_f[12];
    logic [31:0] t_a[12], t_b[12], t_r[12];
    bit          t_fast[12];

    initial begin
        int cyc, bad;
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] pool[6];

        t_f = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd7};
        t_a = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                32'd7, 32'd7, 32'd5, 32'd5};
        t_b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0};
        t_r = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14,
                32'd2, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'd5};
        t_fast = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", result, 0);

        // Directed ISA cases from the plan
        for (int i = 0; i < 12; i++)
            run_op($sformatf("dir%0d", i), t_f[i], t_a[i], t_b[i],
                   t_r[i], t_fast[i]);

        // done is one pulse; result holds afterwards
        held = result;
        @(posedge clk);
        #1;
        chk("pulse_done", {31'b0, done}, 0);
        chk("hold_result", result, held);

        // Signed overflow fast paths
        run_op("ovf_div", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1);
        run_op("ovf_rem", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Start during busy is ignored
        @(posedge clk);
        #1;
        launch(3'd5, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        funct3 = 3'd0;
        a      = 32'd3;
        b      = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, 0, cyc, bad);
        chk("ign_cycle", cyc, 34);
        chk("ign_busy", bad, 0);
        chk("ign_res", result, 32'd14);

        // Back-to-back: start in the DONE cycle
        launch(3'd7, 32'd100, 32'd7);
        wait_done(1, 0, cyc, bad);
        chk("b2b_cycle", cyc, 34);
        chk("b2b_busy", bad, 0);
        chk("b2b_res", result, 32'd2);

        // Reset at cycle 15 of a DIV, with start also high
        @(posedge clk);
        #1;
        launch(3'd4, 32'd1000, 32'd3);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        start = 1'b1;
        funct3 = 3'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_result", result, 0);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_quiet", bad, 0);
        run_op("post_mul", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Randomized ops against the reference model
        pool = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                 32'h7FFF_FFFF, 32'd2};
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                             : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                             : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rnd%0d_f%0d_%h_%h", i, rf, ra, rb), rf, ra, rb,
                   ref_md(rf, ra, rb), ref_fast(rf, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
